// File: rtl/ws2811_gamma_lut.sv
// rtl/ws2811_gamma_lut.sv - programmable pipelined multi-channel gamma LUT for the WS2811 pixel path
//
// Purpose: per-channel host-writable lookup RAMs, self-filled with an identity
// curve after reset or on init_req, applied to a valid/ready pixel stream.
// The stream has full backpressure and one global stall.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready/in_data   pixel input, channel 0 in the LSBs
//   out_valid/out_ready/out_data corrected pixel output, channel 0 in the LSBs
//   wr_en/wr_chan/wr_addr/wr_data host table write, honoured only while not busy
//   init_req                 one-cycle pulse restarting the identity fill
//   busy                     identity fill in progress
//   brightness               (WS2811_GAMMA_BRIGHTNESS_EN only) 8-bit output scale
//
// Optional feature macro: WS2811_GAMMA_BRIGHTNESS_EN adds a third stage that
// scales every channel by (brightness + 1) / 256.
module ws2811_gamma_lut #(
  parameter int DIN_W    = 8,
  parameter int DOUT_W   = 8,
  parameter int CHANNELS = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*DIN_W-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*DOUT_W-1:0]   out_data,
  input  logic                         wr_en,
  input  logic [$clog2(CHANNELS)-1:0]  wr_chan,
  input  logic [DIN_W-1:0]             wr_addr,
  input  logic [DOUT_W-1:0]            wr_data,
  input  logic                         init_req,
  output logic                         busy
`ifdef WS2811_GAMMA_BRIGHTNESS_EN
  ,
  input  logic [7:0]                   brightness
`endif
);

  localparam int DEPTH = 1 << DIN_W;

  typedef enum logic {INIT, RUN} state_t;

  state_t                       state, state_nxt;
  logic [DIN_W-1:0]             cnt, cnt_nxt;
  logic [DOUT_W-1:0]            fill_val;
  logic [DIN_W-1:0]             mem_addr;
  logic [DOUT_W-1:0]            mem_wdata;
  logic                         advance;
  logic                         accept;
  logic                         tail_valid;
  logic [CHANNELS*DOUT_W-1:0]   rd_data;
  logic                         s1_valid;
  logic                         s2_valid;
  logic [CHANNELS*DOUT_W-1:0]   s2_data;

  // Fill controller
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      INIT: begin
        if (init_req) begin
          cnt_nxt = '0;
        end else begin
          // Counter wraps to zero on the last entry, ready for the next fill.
          cnt_nxt = cnt + 1'b1;
          if (cnt == '1) state_nxt = RUN;
        end
      end
      RUN: begin
        if (init_req) begin
          state_nxt = INIT;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = INIT;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy = (state == INIT);

  // Identity entry: index left-aligned in the output word.
  assign fill_val = DOUT_W'(cnt) << (DOUT_W - DIN_W);

  // The fill owns the write port while busy; host writes are dropped then.
  assign mem_addr  = busy ? cnt : wr_addr;
  assign mem_wdata = busy ? fill_val : wr_data;

  // Stream handshake: one global stall for every stage.
  assign advance  = !tail_valid || out_ready;
  assign in_ready = !busy && advance;
  assign accept   = in_valid && in_ready;

  // Per-channel tables, read-first: a same-cycle write to the read entry
  // is seen only by later lookups.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    logic [DOUT_W-1:0] mem [DEPTH];
    logic [DOUT_W-1:0] rd;
    logic              we;

    assign we = busy || (wr_en && (int'(wr_chan) == c));

    always_ff @(posedge clk) begin
      if (advance) rd <= mem[in_data[c*DIN_W +: DIN_W]];
      if (we) mem[mem_addr] <= mem_wdata;
    end

    assign rd_data[c*DOUT_W +: DOUT_W] = rd;
  end

  // S1 valid tracks the RAM read register, S2 is the lookup result register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
    end else if (advance) begin
      s1_valid <= accept;
      s2_valid <= s1_valid;
      s2_data  <= rd_data;
    end
  end

`ifdef WS2811_GAMMA_BRIGHTNESS_EN
  logic                         s3_valid;
  logic [CHANNELS*DOUT_W-1:0]   s3_data;
  logic [CHANNELS*DOUT_W-1:0]   scaled;
  logic [DOUT_W+8:0]            prod;

  // lut * (brightness + 1) >> 8; brightness 255 is an exact pass-through.
  always_comb begin
    scaled = '0;
    prod   = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      prod = (DOUT_W+9)'(s2_data[c*DOUT_W +: DOUT_W]) *
             (DOUT_W+9)'({1'b0, brightness} + 9'd1);
      scaled[c*DOUT_W +: DOUT_W] = prod[DOUT_W+7:8];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s3_valid <= 1'b0;
      s3_data  <= '0;
    end else if (advance) begin
      s3_valid <= s2_valid;
      s3_data  <= scaled;
    end
  end

  assign tail_valid = s3_valid;
  assign out_valid  = s3_valid;
  assign out_data   = s3_data;
`else
  assign tail_valid = s2_valid;
  assign out_valid  = s2_valid;
  assign out_data   = s2_data;
`endif

endmodule

// File: tb/tb_ws2811_gamma_lut.sv
// tb/tb_ws2811_gamma_lut.sv - self-checking bench for ws2811_gamma_lut
module tb_ws2811_gamma_lut;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_chan = '0;
  logic [7:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic        init_req = 1'b0;
  logic        busy;
`ifdef WS2811_GAMMA_BRIGHTNESS_EN
  logic [7:0]  brightness = 8'd255;
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  int          exp_fill = 0;
  logic [7:0]  tab [3][256];
  logic [23:0] sb [$];
  logic        held = 1'b0;
  logic [23:0] held_data = '0;
  logic        last_acc = 1'b0;
  int          idx;
  int          cyc;

  ws2811_gamma_lut #(.DIN_W(8), .DOUT_W(8), .CHANNELS(3)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .wr_en(wr_en), .wr_chan(wr_chan), .wr_addr(wr_addr), .wr_data(wr_data),
    .init_req(init_req), .busy(busy)
`ifdef WS2811_GAMMA_BRIGHTNESS_EN
    , .brightness(brightness)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic identity();
    for (int c = 0; c < 3; c++)
      for (int a = 0; a < 256; a++) tab[c][a] = 8'(a);
  endtask

  function automatic logic [23:0] model(input logic [23:0] pix);
    logic [23:0] o;
    logic [7:0]  v;
    logic [15:0] p;
    o = '0;
    for (int c = 0; c < 3; c++) begin
      v = tab[c][pix[c*8 +: 8]];
`ifdef WS2811_GAMMA_BRIGHTNESS_EN
      p = 16'(v) * (16'(brightness) + 16'd1);
`else
      p = {v, 8'h00};
`endif
      o[c*8 +: 8] = p[15:8];
    end
    return o;
  endfunction

  // One clock: sample between edges, score handshakes, update the model, step.
  task automatic cycle();
    #1;
    chk("busy", 32'(busy), 32'(exp_fill != 0));
    chk("in_ready", 32'(in_ready), 32'((exp_fill == 0) && (!out_valid || out_ready)));
    if (held) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data), 32'(held_data));
    end
    if (out_valid) begin
      chk("sb_has_entry", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        chk("sb_data", 32'(out_data), 32'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
    last_acc = in_valid && in_ready;
    if (last_acc) sb.push_back(model(in_data));
    if (wr_en && exp_fill == 0 && wr_chan < 2'd3) tab[wr_chan][wr_addr] = wr_data;
    held = out_valid && !out_ready;
    held_data = out_data;
    @(posedge clk);
    if (init_req) begin
      exp_fill = 256;
      identity();
    end else if (exp_fill > 0) begin
      exp_fill--;
    end
    @(negedge clk);
  endtask

  task automatic send_one(input logic [23:0] pix, input logic [23:0] exp, input string tag);
    int n;
    in_valid = 1'b1;
    in_data  = pix;
    n = 0;
    do begin cycle(); n++; end while (!last_acc && n < 20);
    in_valid = 1'b0;
    chk({tag, "_accept"}, 32'(last_acc), 32'd1);
    n = 0;
    while (!out_valid && n < 20) begin cycle(); n++; end
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk(tag, 32'(out_data), 32'(exp));
    cycle();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin cycle(); n++; end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  task automatic host_write(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] d);
    wr_en = 1'b1; wr_chan = ch; wr_addr = a; wr_data = d;
    cycle();
    wr_en = 1'b0;
  endtask

  initial begin
    identity();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);

    // Reset release: busy must stay high for exactly 256 cycles.
    rst = 1'b0;
    exp_fill = 256;
    identity();
    repeat (260) cycle();

    // Latency of the first lookup through the identity curve.
    in_valid = 1'b1;
    in_data  = 24'h302010;
    cycle();
    chk("t1_accept", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    for (int k = 1; k < LAT; k++) begin
      chk("t1_early", 32'(out_valid), 32'd0);
      cycle();
    end
    chk("t1_lat_valid", 32'(out_valid), 32'd1);
    chk("t1_data", 32'(out_data), 32'h302010);
    cycle();

    // Host writes, including one to a nonexistent channel.
    host_write(2'd1, 8'h80, 8'h25);
    host_write(2'd2, 8'hFF, 8'h00);
    host_write(2'd3, 8'h10, 8'hAA);
    send_one(24'hFF8080, 24'h002580, "t2_custom");
    send_one(24'h101010, 24'h101010, "t2_bad_chan");

    // 16 incrementing pixels with downstream stalled on cycles 4..8.
    idx = 0;
    cyc = 0;
    while ((idx < 16 || sb.size() != 0) && cyc < 100) begin
      in_valid  = (idx < 16);
      in_data   = 24'h302010 + {3{8'(idx)}};
      out_ready = !(cyc >= 4 && cyc <= 8);
      cycle();
      if (last_acc) idx++;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("t3_all_sent", 32'(idx), 32'd16);
    chk("t3_all_recv", 32'(sb.size()), 32'd0);

    // Same-cycle write and lookup returns the old entry; next lookup the new.
    in_valid = 1'b1;
    in_data  = 24'h000040;
    wr_en = 1'b1; wr_chan = 2'd0; wr_addr = 8'h40; wr_data = 8'h99;
    cycle();
    chk("t4_accept0", 32'(last_acc), 32'd1);
    wr_en = 1'b0;
    cycle();
    chk("t4_accept1", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 20) begin cycle(); cyc++; end
    chk("t4_old", 32'(out_data), 32'h000040);
    cycle();
    chk("t4_new_valid", 32'(out_valid), 32'd1);
    chk("t4_new", 32'(out_data), 32'h000099);
    cycle();
    drain();

    // init_req with two custom-mapped pixels in flight.
    host_write(2'd0, 8'h80, 8'h77);
    in_valid = 1'b1;
    in_data  = 24'h000080;
    cycle();
    in_data  = 24'h008080;
    cycle();
    chk("t5_two_in_flight", 32'(sb.size()), 32'd2);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    init_req  = 1'b1;
    cycle();
    init_req  = 1'b0;
    host_write(2'd0, 8'h80, 8'h11);
    in_valid = 1'b1;
    in_data  = 24'h000080;
    repeat (3) cycle();
    chk("t5_no_accept_busy", 32'(last_acc), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();
    cyc = 0;
    while (exp_fill != 0 && cyc < 300) begin cycle(); cyc++; end
    chk("t5_fill_done", 32'(exp_fill), 32'd0);
    cycle();
    send_one(24'h808080, 24'h808080, "t5_identity");
    send_one(24'hFF0000, 24'hFF0000, "t5_identity_ff");

`ifdef WS2811_GAMMA_BRIGHTNESS_EN
    brightness = 8'd127;
    send_one(24'h0000FF, 24'h00007F, "t6_half");
    brightness = 8'd255;
    send_one(24'h0000FF, 24'h0000FF, "t6_full");
`endif

    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
